// File: rtl/mult_share_arbiter_pkg.sv
// mult_arb_pkg: shared types and defaults for mult_share_arbiter.
//   NUM_REQ_DEF / WIDTH_DEF / MUL_LAT_DEF : default parameter values
//   TAG_ID_W                              : id field width in a tag (covers up to 8 requesters)
//   id_w()                                : index width needed for n requesters
//   tag_t                                 : in-flight tag {valid, id}
package mult_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int MUL_LAT_DEF = 0;
  localparam int TAG_ID_W    = 3;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester, response and multiplier-core signals.
//   req_valid/req_ready/req_a/req_b : requester side (operand i at [i*WIDTH +: WIDTH])
//   rsp_valid/rsp_data              : one-hot response pulse and product
//   mul_a/mul_b/mul_p               : operands to and product from the shared core
// Handshake: a requester transfers its operands in a cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational and may only be high while
// req_valid is high. Responses carry no ready and cannot be stalled.
// modport slave  : the arbiter view
// modport master : the requesters + core view
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [2*WIDTH-1:0]       mul_p;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]       rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_REQ requesters.
//   clk, rst_n : clock, async active-low reset
//   i_en       : 0 suppresses all grants
//   i_req      : request vector
//   i_hs       : a handshake happened this cycle; pointer moves to o_idx
//   o_grant    : one-hot grant (zero when no request or i_en=0)
//   o_idx      : index of the granted requester
// The pointer holds the last granted index; search starts one past it.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_hs,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_en && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    o_grant[o_idx] = w_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (i_hs) begin
      r_ptr <= o_idx;
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one external WIDTH x WIDTH unsigned multiplier
// between NUM_REQ requesters, one issue per cycle, fully pipelined.
//   clk, rst_n : clock, async active-low reset
//   en         : 1 allows new grants; in-flight ops always complete
//   bus        : mult_share_arbiter_if.slave (requests, responses, core operands/product)
//   busy       : any tag stage valid or a response pulse this cycle
//   perf_cnt   : per-requester saturating handshake counters, 32 bits each
// Optional feature: define MULT_ARB_PERF_EN to build the perf counters;
// otherwise perf_cnt is tied to zero.
// MUL_LAT is the core latency in clock edges from mul_a/mul_b to mul_p.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  mult_share_arbiter_if.slave   bus,
  output logic                  busy,
  output logic [NUM_REQ*32-1:0] perf_cnt
);
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_hs;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_tag_busy;

  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  tag_t               r_tag [MUL_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [2*WIDTH-1:0] r_rsp_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_req   (bus.req_valid),
    .i_hs    (w_hs),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign bus.req_ready = w_grant;
  assign w_hs          = |(bus.req_valid & w_grant);

  // Operands hold their last value when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_hs) begin
      r_mul_a <= bus.req_a[w_idx*WIDTH +: WIDTH];
      r_mul_b <= bus.req_b[w_idx*WIDTH +: WIDTH];
    end
  end

  assign bus.mul_a = r_mul_a;
  assign bus.mul_b = r_mul_b;

  // Tag pipeline mirrors the core latency so stage MUL_LAT lines up with mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= MUL_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].valid <= w_hs;
      r_tag[0].id    <= w_hs ? TAG_ID_W'(w_idx) : '0;
      for (int k = 1; k <= MUL_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_onehot = NUM_REQ'(1) << r_tag[MUL_LAT].id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else if (r_tag[MUL_LAT].valid) begin
      r_rsp_valid <= w_onehot;
      r_rsp_data  <= bus.mul_p;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  always_comb begin
    w_tag_busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) w_tag_busy = w_tag_busy | r_tag[k].valid;
  end

  assign busy = w_tag_busy | (|r_rsp_valid);

`ifdef MULT_ARB_PERF_EN
  logic [31:0] r_perf [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_perf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_hs && w_grant[i] && (r_perf[i] != 32'hFFFF_FFFF)) r_perf[i] <= r_perf[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_cnt[g*32 +: 32] = r_perf[g];
  end
`else
  assign perf_cnt = '0;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: bench for mult_share_arbiter.
// dut0 uses a combinational core (MUL_LAT=0), dut3 a 3-stage core (MUL_LAT=3).
// Perf counter expectations follow MULT_ARB_PERF_EN.
module tb_mult_share_arbiter;
  logic clk;
  logic rst_n;
  logic en;
  logic busy0, busy3;
  logic [127:0] perf0, perf3;
  int cyc;
  int n_checks;
  int n_fail;

  // expected entry: {rsp cycle[15:0], id[1:0], product[31:0]}
  logic [49:0] exp_q0[$];
  logic [49:0] exp_q3[$];
  int ptr0, ptr3;
  int hs_cnt0 [4];

  mult_share_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) bus0 ();
  mult_share_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) bus3 ();

  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus0), .busy(busy0), .perf_cnt(perf0)
  );
  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus3), .busy(busy3), .perf_cnt(perf3)
  );

  // ---------------- clock / cores ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus0.mul_p = 32'(bus0.mul_a) * 32'(bus0.mul_b);

  logic [31:0] core3 [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core3[0] <= '0; core3[1] <= '0; core3[2] <= '0;
    end else begin
      core3[0] <= 32'(bus3.mul_a) * 32'(bus3.mul_b);
      core3[1] <= core3[0];
      core3[2] <= core3[1];
    end
  end
  assign bus3.mul_p = core3[2];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rr_model(input logic [3:0] v, input int p, input logic e);
    logic [3:0] g;
    g = '0;
    if (e) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (p + k) % 4;
        if (v[c] && (g == 4'b0000)) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

  // Per-cycle scoreboard step for one DUT; d=0 -> dut0, d=1 -> dut3.
  task automatic mon(input int d, input int lat, input logic e, input logic [3:0] v,
                     input logic [3:0] rdy, input logic [63:0] a, input logic [63:0] b,
                     input logic [3:0] rv, input logic [31:0] rd, input logic bsy);
    logic [49:0] ent;
    logic [3:0]  one;
    logic [31:0] prod;
    int sz, p, idx;
    string s;
    s  = (d == 0) ? "d0" : "d3";
    sz = (d == 0) ? exp_q0.size() : exp_q3.size();
    p  = (d == 0) ? ptr0 : ptr3;
    check({s, "_busy"}, bsy, (sz != 0));
    check({s, "_grant"}, rdy, rr_model(v, p, e));
    if (rv != 4'b0000) begin
      if (sz == 0) begin
        check({s, "_rsp_unexpected"}, rv, 4'b0000);
      end else begin
        ent = (d == 0) ? exp_q0.pop_front() : exp_q3.pop_front();
        one = 4'b0001;
        check({s, "_rsp_onehot"}, rv, one << ent[33:32]);
        check({s, "_rsp_data"}, rd, ent[31:0]);
        check({s, "_rsp_cycle"}, 16'(cyc), ent[49:34]);
      end
    end
    if ((v & rdy) != 4'b0000) begin
      idx = 0;
      for (int i = 3; i >= 0; i--) if (v[i] && rdy[i]) idx = i;
      prod = 32'(a[idx*16 +: 16]) * 32'(b[idx*16 +: 16]);
      ent  = {16'(cyc + lat + 2), 2'(idx), prod};
      if (d == 0) begin
        exp_q0.push_back(ent); ptr0 = idx; hs_cnt0[idx]++;
      end else begin
        exp_q3.push_back(ent); ptr3 = idx;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete(); exp_q3.delete();
      ptr0 = 3; ptr3 = 3;
      for (int i = 0; i < 4; i++) hs_cnt0[i] = 0;
    end else begin
      mon(0, 0, en, bus0.req_valid, bus0.req_ready, bus0.req_a, bus0.req_b,
          bus0.rsp_valid, bus0.rsp_data, busy0);
      mon(1, 3, en, bus3.req_valid, bus3.req_ready, bus3.req_a, bus3.req_b,
          bus3.rsp_valid, bus3.rsp_data, busy3);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [15:0] a, input logic [15:0] b);
    bit done;
    done = 1'b0;
    bus0.req_valid[idx] = 1'b1;
    bus0.req_a[idx*16 +: 16] = a;
    bus0.req_b[idx*16 +: 16] = b;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (bus0.req_ready[idx]) done = 1'b1;
    end
    check("issue_handshake", done, 1'b1);
    tick(1);
    bus0.req_valid[idx] = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_mul_a", bus0.mul_a, 16'h0);
    check("rst_mul_b", bus0.mul_b, 16'h0);
    check("rst_rsp_valid", bus0.rsp_valid, 4'h0);
    check("rst_rsp_data", bus0.rsp_data, 32'h0);
    check("rst_busy", busy0, 1'b0);
    check("rst_busy3", busy3, 1'b0);
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && (exp_q0.size() != 0 || exp_q3.size() != 0); t++) tick(1);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q3", exp_q3.size(), 0);
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b0;
    bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    check("rst_ready", bus0.req_ready, 4'h0);
    tick(1);
    rst_n = 1'b1; en = 1'b1;

    // 10 back-to-back req2 ops on the MUL_LAT=3 instance
    bus3.req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      bus3.req_a[2*16 +: 16] = 16'(k * 1000 + 7);
      bus3.req_b[2*16 +: 16] = 16'(k * 77 + 3);
      tick(1);
    end
    bus3.req_valid = '0;
    drain();
`ifdef MULT_ARB_PERF_EN
    check("perf3_r0", perf3[0*32 +: 32], 32'd0);
    check("perf3_r1", perf3[1*32 +: 32], 32'd0);
    check("perf3_r2", perf3[2*32 +: 32], 32'd10);
    check("perf3_r3", perf3[3*32 +: 32], 32'd0);
`else
    check("perf3_off", perf3, 128'h0);
`endif

    // single op and operand boundaries
    issue(0, 16'd3, 16'd5);
    drain();
    issue(0, 16'hFFFF, 16'hFFFF);
    issue(1, 16'h0000, 16'hFFFF);
    drain();

    // all four requesters valid continuously
    for (int i = 0; i < 4; i++) begin
      bus0.req_a[i*16 +: 16] = 16'(i + 1);
      bus0.req_b[i*16 +: 16] = 16'd2;
    end
    bus0.req_valid = 4'b1111;
    tick(8);
    bus0.req_valid = '0;
    drain();

    // two ops then en=0 with requests still pending
    bus0.req_valid = 4'b0011;
    tick(2);
    en = 1'b0;
    tick(5);
    bus0.req_valid = '0;
    en = 1'b1;
    drain();

    // reset with ops in flight
    bus0.req_valid = 4'b0011;
    tick(2);
    rst_n = 1'b0;
    bus0.req_valid = '0;
    @(negedge clk);
    check_reset_state();
    tick(1);
    rst_n = 1'b1;
    tick(6);
    bus0.req_valid = 4'b1001;
    @(negedge clk);
    check("post_rst_first", bus0.req_ready, 4'b0001);
    tick(2);
    bus0.req_valid = '0;
    drain();

    // random traffic
    for (int k = 0; k < 150; k++) begin
      bus0.req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        bus0.req_a[i*16 +: 16] = 16'($urandom_range(0, 65535));
        bus0.req_b[i*16 +: 16] = 16'($urandom_range(0, 65535));
      end
      en = ($urandom_range(0, 7) != 0);
      tick(1);
    end
    bus0.req_valid = '0;
    en = 1'b1;
    drain();
`ifdef MULT_ARB_PERF_EN
    for (int i = 0; i < 4; i++) check($sformatf("perf0_r%0d", i), perf0[i*32 +: 32], 32'(hs_cnt0[i]));
`else
    check("perf0_off", perf0, 128'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
